pe_mac_gen2: RTL and testbench
==============================

Name: pe_mac_gen2

Overview:
- Parametrised successor of the row-stationary PE.
- Loads a filter set, then slides an ifmap window across F output columns.
- Per column: accepts input psums, runs a pipelined signed MAC sequence, and streams output psums.
- Adds over the previous generation:
  - generic lane, width and channel counts
  - a configurable multiplier pipeline depth
  - programmable ifmap zero-point handling
  - saturating accumulation and optional ReLU
  - busy/done status
- Sits in the PE array; all streams are valid/ready.

Parameters:
ACT_W, 8, activation/weight element width (signed)
LANES, 4, elements packed per ifmap/filter word; DATA_W = ACT_W*LANES (localparam)
PSUM_W, 32, psum width (signed)
MAX_P, 4, max output channels
MAX_Q, 4, max input channels per tap row; must be a multiple of LANES
MAX_RS, 3, max filter taps per row
MAX_F, 32, max output columns
MUL_STAGES, 2, register stages between operand fetch and accumulate (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
PE_en  in  1  start pulse; sampled only in IDLE
cfg_depthwise  in  1  1 = depthwise (Q outputs), 0 = standard (P outputs)
cfg_p_m1  in  clog2(MAX_P)  output channels - 1
cfg_q_m1  in  clog2(MAX_Q)  input channels - 1
cfg_rs_m1  in  clog2(MAX_RS)  taps - 1
cfg_f_m1  in  clog2(MAX_F)  output columns - 1
cfg_relu  in  1  clamp negative opsum to 0
cfg_ifmap_unsigned  in  1  ifmap is uint8 (offset 128); invert element MSB on load
filter  in  DATA_W  packed filter word
filter_valid / filter_ready  in / out  1  filter handshake
ifmap  in  DATA_W  packed ifmap word
ifmap_valid / ifmap_ready  in / out  1  ifmap handshake
ipsum  in  PSUM_W  input psum
ipsum_valid / ipsum_ready  in / out  1  ipsum handshake
opsum  out  PSUM_W  output psum
opsum_valid / opsum_ready  out / in  1  opsum handshake
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after last opsum of last column accepted

Behaviour:
- Reset (sync, any state including mid-operation):
  - state=IDLE; all counters 0; psum spad 0.
  - All ready/valid, busy, done = 0; opsum = 0.
  - Filter/ifmap spad contents are don't-care.
- Config is latched on the PE_en cycle in IDLE and held until return to IDLE. PE_en outside IDLE is ignored.
- Derived counts: C = q_m1+1, RS = rs_m1+1, NOUT = depthwise ? C : p_m1+1.
- Layout: element index e maps to word e/LANES, lane e%LANES (lane 0 = LSBs).
  - Filter (p,r,q) is at e = (p*RS+r)*MAX_Q+q.
  - Ifmap (r,q) is at e = r*MAX_Q+q.
  - Unused q slots are loaded but ignored.
- States:
  - IDLE -> LOAD_FILTER on PE_en.
  - LOAD_FILTER: filter_ready=1. Accept ceil((depthwise?1:P)*RS*MAX_Q/LANES) words, then -> LOAD_IFMAP.
  - LOAD_IFMAP: ifmap_ready=1.
    - Column 0 accepts RS*MAX_Q/LANES words.
    - Later columns: spad first shifts down by MAX_Q elements (done on the WRITE_OPSUM exit cycle), then accepts MAX_Q/LANES words into tap row RS-1.
    - -> LOAD_IPSUM after the last accepted word.
  - LOAD_IPSUM: ipsum_ready=1. Accept NOUT words into psum[0..NOUT-1] in order, then -> COMPUTE.
  - COMPUTE: issue exactly one MAC per cycle, no bubbles.
    - Standard order: p outer, r, q inner; psum[p] += f(p,r,q)*x(r,q).
    - Depthwise order: r outer, q inner; psum[q] += f(0,r,q)*x(r,q).
    - Issue count is NOUT*RS*C (standard) or RS*C (depthwise). -> DRAIN after the last issue.
  - DRAIN: wait MUL_STAGES cycles so every product has been accumulated, then -> WRITE_OPSUM.
  - WRITE_OPSUM:
    - opsum = relu ? max(psum[k],0) : psum[k], with opsum_valid=1.
    - opsum and opsum_valid are held stable until opsum_ready; k advances per accept.
    - After accept of k = NOUT-1: if col == f_m1 -> IDLE with done=1 that cycle; else col++ and -> LOAD_IFMAP.
- Arithmetic:
  - Operands are signed ACT_W; the product is an exact signed 2*ACT_W value, sign-extended.
  - Accumulate saturates to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
  - Back-to-back products to the same psum index must be forwarded; the result must equal the sequential sum with per-step saturation.
- Stalls: valid low in a LOAD state holds the state and counters. opsum_ready low holds output.
- The first accepted word of each handshake moves data in the same cycle valid&ready are both high.

Test Plan:
1. Standard, P=1, C=4, RS=3, F=1, filter all 1, ifmap all 2, ipsum=10, unsigned=0 -> single opsum 34, then done pulse, busy=0.
2. Depthwise, C=4, RS=3, F=2, filter(r,q)=q+1, ifmap column0 x=1 / column1 x=-1 rows, ipsum 0 -> col0 opsums 3,6,9,12; col1 values per shifted window.
3. cfg_ifmap_unsigned=1, ifmap byte 0x00, filter 1, P=1, C=1, RS=1 -> opsum = ipsum-128. With cfg_relu=1 and ipsum=0 -> opsum 0.
4. Saturation: ipsum=0x7FFFFFF0, products 127*127 -> opsum 0x7FFFFFFF. Negative case -> 0x80000000.
5. Backpressure: hold opsum_ready=0 for 5 cycles, toggle filter_valid randomly -> opsum stable and results unchanged vs. no-stall run.
6. Assert rst during COMPUTE, then restart with PE_en -> outputs zeroed next cycle; second run results match a golden model.

Source files
------------

// File: rtl/pe_mac_gen2_if.sv
// Stream bundle for pe_mac_gen2: filter/ifmap/ipsum inputs and opsum output, all valid/ready.
// The master modport belongs to the feeder; the slave modport belongs to the PE.
interface pe_mac_gen2_if #(
    parameter int DATA_W = 32,
    parameter int PSUM_W = 32
);
    logic [DATA_W-1:0] filter;
    logic              filter_valid;
    logic              filter_ready;
    logic [DATA_W-1:0] ifmap;
    logic              ifmap_valid;
    logic              ifmap_ready;
    logic [PSUM_W-1:0] ipsum;
    logic              ipsum_valid;
    logic              ipsum_ready;
    logic [PSUM_W-1:0] opsum;
    logic              opsum_valid;
    logic              opsum_ready;

    modport master (
        output filter, filter_valid, input filter_ready,
        output ifmap, ifmap_valid, input ifmap_ready,
        output ipsum, ipsum_valid, input ipsum_ready,
        input opsum, opsum_valid, output opsum_ready
    );

    modport slave (
        input filter, filter_valid, output filter_ready,
        input ifmap, ifmap_valid, output ifmap_ready,
        input ipsum, ipsum_valid, output ipsum_ready,
        output opsum, opsum_valid, input opsum_ready
    );
endinterface

// File: rtl/pe_mac_gen2.sv
// Row-stationary PE, second generation: loads filters, slides an ifmap window over F columns,
// and runs a pipelined saturating signed MAC per column.
module pe_mac_gen2 #(
    parameter int ACT_W      = 8,
    parameter int LANES      = 4,
    parameter int PSUM_W     = 32,
    parameter int MAX_P      = 4,
    parameter int MAX_Q      = 4,
    parameter int MAX_RS     = 3,
    parameter int MAX_F      = 32,
    parameter int MUL_STAGES = 2,
    localparam int DATA_W    = ACT_W * LANES,
    localparam int PW        = (MAX_P > 1) ? $clog2(MAX_P) : 1,
    localparam int QB        = (MAX_Q > 1) ? $clog2(MAX_Q) : 1,
    localparam int RB        = (MAX_RS > 1) ? $clog2(MAX_RS) : 1,
    localparam int FB        = (MAX_F > 1) ? $clog2(MAX_F) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          PE_en,
    input  logic          cfg_depthwise,
    input  logic [PW-1:0] cfg_p_m1,
    input  logic [QB-1:0] cfg_q_m1,
    input  logic [RB-1:0] cfg_rs_m1,
    input  logic [FB-1:0] cfg_f_m1,
    input  logic          cfg_relu,
    input  logic          cfg_ifmap_unsigned,
    pe_mac_gen2_if.slave  bus,
    output logic          busy,
    output logic          done
);
    localparam int QW      = MAX_Q / LANES;
    localparam int F_ELEMS = MAX_P * MAX_RS * MAX_Q;
    localparam int I_ELEMS = MAX_RS * MAX_Q;
    localparam int NPS     = (MAX_P > MAX_Q) ? MAX_P : MAX_Q;
    localparam int FE_AW   = (F_ELEMS > 1) ? $clog2(F_ELEMS) : 1;
    localparam int IE_AW   = (I_ELEMS > 1) ? $clog2(I_ELEMS) : 1;
    localparam int PS_AW   = (NPS > 1) ? $clog2(NPS) : 1;
    localparam int NB      = (PW > QB) ? PW : QB;
    localparam int CNT_W   = $clog2(F_ELEMS / LANES + NPS + 1);
    localparam int DR_W    = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam int PROD_W  = 2 * ACT_W;

    typedef enum logic [2:0] {
        IDLE, LOAD_FILTER, LOAD_IFMAP, LOAD_IPSUM, COMPUTE, DRAIN, WRITE_OPSUM
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FB-1:0]       col_q, col_d;
    logic [PW-1:0]       p_q, p_d;
    logic [RB-1:0]       r_q, r_d;
    logic [QB-1:0]       q_q, q_d;
    logic [DR_W-1:0]     drain_q, drain_d;
    logic                done_q, done_d;
    logic                dw_q, dw_d, relu_q, relu_d, uns_q, uns_d;
    logic [PW-1:0]       p_m1_q, p_m1_d;
    logic [QB-1:0]       q_m1_q, q_m1_d;
    logic [RB-1:0]       rs_m1_q, rs_m1_d;
    logic [FB-1:0]       f_m1_q, f_m1_d;

    logic signed [ACT_W-1:0]  fspad_q [F_ELEMS];
    logic signed [ACT_W-1:0]  fspad_d [F_ELEMS];
    logic signed [ACT_W-1:0]  ispad_q [I_ELEMS];
    logic signed [ACT_W-1:0]  ispad_d [I_ELEMS];
    logic signed [PSUM_W-1:0] psum_q [NPS];
    logic signed [PSUM_W-1:0] psum_d [NPS];

    logic signed [PROD_W-1:0] prod_q [MUL_STAGES];
    logic signed [PROD_W-1:0] prod_d [MUL_STAGES];
    logic [PS_AW-1:0]         idx_q [MUL_STAGES];
    logic [PS_AW-1:0]         idx_d [MUL_STAGES];
    logic [MUL_STAGES-1:0]    vld_q, vld_d;

    logic                     issue;
    logic [NB-1:0]            nout_m1;
    logic [CNT_W-1:0]         fw_last, iw_last;
    logic [FE_AW-1:0]         f_e;
    logic [IE_AW-1:0]         i_e;
    logic signed [PROD_W-1:0] mac_prod;
    logic [PS_AW-1:0]         mac_idx;
    logic signed [PSUM_W-1:0] acc_old, acc_sat, out_val;
    logic signed [PSUM_W:0]   acc_wide;

    assign nout_m1  = dw_q ? NB'(q_m1_q) : NB'(p_m1_q);
    assign fw_last  = CNT_W'((dw_q ? 1 : int'(p_m1_q) + 1) * (int'(rs_m1_q) + 1) * QW - 1);
    assign iw_last  = CNT_W'(((col_q == '0) ? (int'(rs_m1_q) + 1) * QW : QW) - 1);
    assign f_e      = FE_AW'(((dw_q ? 0 : int'(p_q)) * (int'(rs_m1_q) + 1) + int'(r_q)) * MAX_Q + int'(q_q));
    assign i_e      = IE_AW'(int'(r_q) * MAX_Q + int'(q_q));
    assign mac_prod = PROD_W'(fspad_q[f_e]) * PROD_W'(ispad_q[i_e]);
    assign mac_idx  = dw_q ? PS_AW'(q_q) : PS_AW'(p_q);

    // Accumulation is a single-cycle read-modify-write, so consecutive products to one psum chain naturally.
    assign acc_old  = psum_q[idx_q[MUL_STAGES-1]];
    assign acc_wide = {acc_old[PSUM_W-1], acc_old}
                    + {{(PSUM_W + 1 - PROD_W){prod_q[MUL_STAGES-1][PROD_W-1]}}, prod_q[MUL_STAGES-1]};
    assign acc_sat  = (acc_wide[PSUM_W] != acc_wide[PSUM_W-1])
                    ? (acc_wide[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}})
                    : acc_wide[PSUM_W-1:0];
    assign out_val  = psum_q[PS_AW'(cnt_q)];

    assign busy = (state_q != IDLE);
    assign done = done_q;

    always_comb begin
        state_d = state_q;   cnt_d = cnt_q;     col_d = col_q;
        p_d = p_q;           r_d = r_q;         q_d = q_q;
        drain_d = drain_q;   done_d = 1'b0;
        dw_d = dw_q;         relu_d = relu_q;   uns_d = uns_q;
        p_m1_d = p_m1_q;     q_m1_d = q_m1_q;   rs_m1_d = rs_m1_q;  f_m1_d = f_m1_q;
        fspad_d = fspad_q;   ispad_d = ispad_q; psum_d = psum_q;
        issue = 1'b0;
        bus.filter_ready = 1'b0;
        bus.ifmap_ready  = 1'b0;
        bus.ipsum_ready  = 1'b0;
        bus.opsum_valid  = 1'b0;
        bus.opsum        = '0;

        if (vld_q[MUL_STAGES-1]) psum_d[idx_q[MUL_STAGES-1]] = acc_sat;

        case (state_q)
            IDLE: begin
                if (PE_en) begin
                    dw_d = cfg_depthwise;  relu_d = cfg_relu;   uns_d = cfg_ifmap_unsigned;
                    p_m1_d = cfg_p_m1;     q_m1_d = cfg_q_m1;   rs_m1_d = cfg_rs_m1;  f_m1_d = cfg_f_m1;
                    cnt_d = '0;
                    col_d = '0;
                    state_d = LOAD_FILTER;
                end
            end
            LOAD_FILTER: begin
                bus.filter_ready = 1'b1;
                if (bus.filter_valid) begin
                    for (int l = 0; l < LANES; l++)
                        fspad_d[FE_AW'(int'(cnt_q) * LANES + l)] = bus.filter[l*ACT_W +: ACT_W];
                    if (cnt_q == fw_last) begin
                        cnt_d = '0;
                        state_d = LOAD_IFMAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_IFMAP: begin
                bus.ifmap_ready = 1'b1;
                if (bus.ifmap_valid) begin
                    // Unsigned activations become signed by flipping the MSB (subtracting the 128 offset).
                    for (int l = 0; l < LANES; l++)
                        ispad_d[IE_AW'(((col_q == '0) ? int'(cnt_q) : int'(rs_m1_q) * QW + int'(cnt_q)) * LANES + l)]
                            = bus.ifmap[l*ACT_W +: ACT_W] ^ {uns_q, {(ACT_W-1){1'b0}}};
                    if (cnt_q == iw_last) begin
                        cnt_d = '0;
                        state_d = LOAD_IPSUM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_IPSUM: begin
                bus.ipsum_ready = 1'b1;
                if (bus.ipsum_valid) begin
                    psum_d[PS_AW'(cnt_q)] = bus.ipsum;
                    if (cnt_q == CNT_W'(nout_m1)) begin
                        cnt_d = '0;
                        p_d = '0;
                        r_d = '0;
                        q_d = '0;
                        state_d = COMPUTE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                issue = 1'b1;
                if (q_q != q_m1_q) begin
                    q_d = q_q + 1'b1;
                end else begin
                    q_d = '0;
                    if (r_q != rs_m1_q) begin
                        r_d = r_q + 1'b1;
                    end else begin
                        r_d = '0;
                        if (dw_q || p_q == p_m1_q) begin
                            drain_d = '0;
                            state_d = DRAIN;
                        end else begin
                            p_d = p_q + 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DR_W'(MUL_STAGES - 1)) begin
                    cnt_d = '0;
                    state_d = WRITE_OPSUM;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            WRITE_OPSUM: begin
                bus.opsum_valid = 1'b1;
                bus.opsum = (relu_q && out_val[PSUM_W-1]) ? '0 : out_val;
                if (bus.opsum_ready) begin
                    if (cnt_q == CNT_W'(nout_m1)) begin
                        cnt_d = '0;
                        if (col_q == f_m1_q) begin
                            done_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            col_d = col_q + 1'b1;
                            for (int i = 0; i < I_ELEMS - MAX_Q; i++) ispad_d[i] = ispad_q[i + MAX_Q];
                            state_d = LOAD_IFMAP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prod_d[0] = mac_prod;
        idx_d[0]  = mac_idx;
        vld_d[0]  = issue;
        for (int i = 1; i < MUL_STAGES; i++) begin
            prod_d[i] = prod_q[i-1];
            idx_d[i]  = idx_q[i-1];
            vld_d[i]  = vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;  cnt_q <= '0;   col_q <= '0;
            p_q <= '0;        r_q <= '0;     q_q <= '0;
            drain_q <= '0;    done_q <= 1'b0;
            dw_q <= 1'b0;     relu_q <= 1'b0; uns_q <= 1'b0;
            p_m1_q <= '0;     q_m1_q <= '0;  rs_m1_q <= '0;  f_m1_q <= '0;
            psum_q <= '{default: '0};
            vld_q <= '0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;    col_q <= col_d;
            p_q <= p_d;          r_q <= r_d;        q_q <= q_d;
            drain_q <= drain_d;  done_q <= done_d;
            dw_q <= dw_d;        relu_q <= relu_d;  uns_q <= uns_d;
            p_m1_q <= p_m1_d;    q_m1_q <= q_m1_d;  rs_m1_q <= rs_m1_d;  f_m1_q <= f_m1_d;
            psum_q <= psum_d;
            vld_q <= vld_d;
        end
    end

    // Scratchpad and pipeline data carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        fspad_q <= fspad_d;
        ispad_q <= ispad_d;
        prod_q  <= prod_d;
        idx_q   <= idx_d;
    end
endmodule

// File: tb/tb_pe_mac_gen2.sv
// Self-checking bench for pe_mac_gen2: directed cases plus randomized runs against a
// per-column saturating dot-product model.
module tb_pe_mac_gen2;
    localparam int ACT_W = 8, LANES = 4, PSUM_W = 32, MAX_P = 4, MAX_Q = 4;
    localparam int MAX_RS = 3, MAX_F = 32, MUL_STAGES = 2;
    localparam int DATA_W = ACT_W * LANES, QW = MAX_Q / LANES, NPS = 4;

    logic clk = 1'b0;
    logic rst, PE_en, cfg_depthwise, cfg_relu, cfg_ifmap_unsigned;
    logic [1:0] cfg_p_m1, cfg_q_m1, cfg_rs_m1;
    logic [4:0] cfg_f_m1;
    logic busy, done;

    pe_mac_gen2_if #(.DATA_W(DATA_W), .PSUM_W(PSUM_W)) bus ();

    pe_mac_gen2 #(
        .ACT_W(ACT_W), .LANES(LANES), .PSUM_W(PSUM_W), .MAX_P(MAX_P), .MAX_Q(MAX_Q),
        .MAX_RS(MAX_RS), .MAX_F(MAX_F), .MUL_STAGES(MUL_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .PE_en(PE_en), .cfg_depthwise(cfg_depthwise),
        .cfg_p_m1(cfg_p_m1), .cfg_q_m1(cfg_q_m1), .cfg_rs_m1(cfg_rs_m1), .cfg_f_m1(cfg_f_m1),
        .cfg_relu(cfg_relu), .cfg_ifmap_unsigned(cfg_ifmap_unsigned),
        .bus(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit hung = 1'b0;
    int dwC, pM1, qM1, rsM1, fM1, reluC, unsC;

    logic signed [7:0] fmem [MAX_P][MAX_RS][MAX_Q];
    logic [7:0]        xraw [MAX_F + MAX_RS][MAX_Q];
    logic [31:0]       ipsumV [MAX_F][NPS];
    logic [31:0]       expV [MAX_F][NPS];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic longint satAdd(input longint a, input longint b);
        longint s;
        s = a + b;
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s;
    endfunction

    function automatic int xval(input int row, input int q);
        logic [7:0] b;
        b = xraw[row][q];
        return unsC ? int'(b) - 128 : int'($signed(b));
    endfunction

    // Each output column c sees ifmap rows c .. c+RS-1; accumulation clamps after every product.
    task automatic buildExpected();
        longint acc;
        int nout;
        nout = dwC ? qM1 + 1 : pM1 + 1;
        for (int c = 0; c <= fM1; c++) begin
            for (int k = 0; k < nout; k++) begin
                acc = longint'($signed(ipsumV[c][k]));
                for (int r = 0; r <= rsM1; r++) begin
                    if (dwC) acc = satAdd(acc, longint'(int'(fmem[0][r][k]) * xval(c + r, k)));
                    else
                        for (int q = 0; q <= qM1; q++)
                            acc = satAdd(acc, longint'(int'(fmem[k][r][q]) * xval(c + r, q)));
                end
                if (reluC != 0 && acc < 0) acc = 0;
                expV[c][k] = 32'(acc);
            end
        end
    endtask

    function automatic logic readyOf(input int ch);
        case (ch)
            0: return bus.filter_ready;
            1: return bus.ifmap_ready;
            default: return bus.ipsum_ready;
        endcase
    endfunction

    task automatic pushWord(input int ch, input logic [31:0] w, input int maxGap, input string tag);
        int guard;
        logic rdy;
        repeat ($urandom_range(0, maxGap)) @(negedge clk);
        case (ch)
            0: begin bus.filter = w; bus.filter_valid = 1'b1; end
            1: begin bus.ifmap = w;  bus.ifmap_valid = 1'b1;  end
            default: begin bus.ipsum = w; bus.ipsum_valid = 1'b1; end
        endcase
        guard = 0;
        rdy = readyOf(ch);
        while (!rdy && guard < (hung ? 0 : 300)) begin
            @(negedge clk);
            guard++;
            rdy = readyOf(ch);
        end
        if (!rdy) hung = 1'b1;
        checkOutput(tag, 64'(rdy), 64'd1);
        @(negedge clk);
        bus.filter_valid = 1'b0;
        bus.ifmap_valid  = 1'b0;
        bus.ipsum_valid  = 1'b0;
    endtask

    task automatic popOpsum(input int c, input int k, input int hold);
        int guard;
        guard = 0;
        while (!bus.opsum_valid && guard < (hung ? 0 : 300)) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.opsum_valid) hung = 1'b1;
        checkOutput($sformatf("opsum_valid c%0d k%0d", c, k), 64'(bus.opsum_valid), 64'd1);
        checkOutput($sformatf("opsum c%0d k%0d", c, k), 64'(bus.opsum), 64'(expV[c][k]));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput($sformatf("opsum_hold c%0d k%0d", c, k),
                        64'({bus.opsum_valid, bus.opsum}), 64'({1'b1, expV[c][k]}));
        end
        bus.opsum_ready = 1'b1;
        @(negedge clk);
        bus.opsum_ready = 1'b0;
    endtask

    task automatic applyStimulus(input int dw, input int pm, input int qm, input int rsm, input int fm,
                                 input int relu, input int uns, input int gap, input int hold,
                                 input bit abortRun, input string name);
        int nfw, niw, nout, e, row, q, t;
        logic [31:0] w;
        dwC = dw; pM1 = pm; qM1 = qm; rsM1 = rsm; fM1 = fm; reluC = relu; unsC = uns;
        buildExpected();
        @(negedge clk);
        cfg_depthwise = dw[0]; cfg_p_m1 = 2'(pm); cfg_q_m1 = 2'(qm); cfg_rs_m1 = 2'(rsm);
        cfg_f_m1 = 5'(fm); cfg_relu = relu[0]; cfg_ifmap_unsigned = uns[0];
        PE_en = 1'b1;
        @(negedge clk);
        PE_en = 1'b0;
        // Scramble the config pins: the PE must work from its latched copy.
        {cfg_depthwise, cfg_p_m1, cfg_q_m1, cfg_rs_m1, cfg_f_m1, cfg_relu, cfg_ifmap_unsigned} = 14'($urandom);
        checkOutput({name, " busy_start"}, 64'(busy), 64'd1);

        nfw = (dw ? 1 : pm + 1) * (rsm + 1) * QW;
        for (int i = 0; i < nfw; i++) begin
            w = '0;
            for (int l = 0; l < LANES; l++) begin
                e = i * LANES + l;
                q = e % MAX_Q;
                t = e / MAX_Q;
                w[l*8 +: 8] = fmem[t / (rsm + 1)][t % (rsm + 1)][q];
            end
            pushWord(0, w, gap, {name, " filter_hs"});
        end

        nout = dw ? qm + 1 : pm + 1;
        for (int c = 0; c <= fm; c++) begin
            niw = (c == 0) ? (rsm + 1) * QW : QW;
            for (int i = 0; i < niw; i++) begin
                w = '0;
                for (int l = 0; l < LANES; l++) begin
                    e = i * LANES + l;
                    row = (c == 0) ? e / MAX_Q : c + rsm;
                    w[l*8 +: 8] = xraw[row][e % MAX_Q];
                end
                pushWord(1, w, gap, {name, " ifmap_hs"});
            end
            for (int k = 0; k < nout; k++) pushWord(2, ipsumV[c][k], gap, {name, " ipsum_hs"});
            if (abortRun) begin
                rst = 1'b1;
                @(negedge clk);
                checkOutput({name, " reset_mid_compute"},
                            64'({busy, done, bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready,
                                 bus.opsum_valid, bus.opsum}), 64'd0);
                rst = 1'b0;
                return;
            end
            for (int k = 0; k < nout; k++) popOpsum(c, k, hold);
        end
        checkOutput({name, " done_pulse"}, 64'({done, busy}), 64'b10);
        @(negedge clk);
        checkOutput({name, " done_clear"}, 64'(done), 64'd0);
    endtask

    task automatic randomData();
        foreach (fmem[p, r, q]) fmem[p][r][q] = 8'($urandom);
        foreach (xraw[r, q]) xraw[r][q] = 8'($urandom);
        foreach (ipsumV[c, k]) begin
            case ($urandom_range(0, 3))
                0: ipsumV[c][k] = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
                1: ipsumV[c][k] = 32'h8000_0000 + 32'($urandom_range(0, 255));
                default: ipsumV[c][k] = 32'($signed($urandom_range(0, 200000)) - 100000);
            endcase
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; PE_en = 1'b0;
        {cfg_depthwise, cfg_p_m1, cfg_q_m1, cfg_rs_m1, cfg_f_m1, cfg_relu, cfg_ifmap_unsigned} = '0;
        bus.filter = '0; bus.filter_valid = 1'b0; bus.ifmap = '0; bus.ifmap_valid = 1'b0;
        bus.ipsum = '0;  bus.ipsum_valid = 1'b0;  bus.opsum_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 64'({busy, done, bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready,
                                        bus.opsum_valid, bus.opsum}), 64'd0);
        rst = 1'b0;

        foreach (fmem[p, r, q]) fmem[p][r][q] = 8'sd1;
        foreach (xraw[r, q]) xraw[r][q] = 8'd2;
        ipsumV[0][0] = 32'd10;
        applyStimulus(0, 0, 3, 2, 0, 0, 0, 0, 0, 1'b0, "t1_basic");

        foreach (fmem[p, r, q]) fmem[p][r][q] = 8'(q + 1);
        foreach (xraw[r, q]) xraw[r][q] = (r < 3) ? 8'd1 : 8'hFF;
        foreach (ipsumV[c, k]) ipsumV[c][k] = '0;
        applyStimulus(1, 0, 3, 2, 1, 0, 0, 1, 1, 1'b0, "t2_depthwise");

        foreach (fmem[p, r, q]) fmem[p][r][q] = 8'sd1;
        foreach (xraw[r, q]) xraw[r][q] = 8'h00;
        ipsumV[0][0] = 32'd5;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 1'b0, "t3_unsigned");
        ipsumV[0][0] = 32'd0;
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0, 1'b0, "t3_relu");

        foreach (fmem[p, r, q]) fmem[p][r][q] = 8'sd127;
        foreach (xraw[r, q]) xraw[r][q] = 8'h7F;
        ipsumV[0][0] = 32'h7FFF_FFF0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, "t4_sat_pos");
        foreach (xraw[r, q]) xraw[r][q] = 8'h80;
        ipsumV[0][0] = 32'h8000_0010;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, "t4_sat_neg");
        foreach (xraw[r, q]) xraw[r][q] = (q < 2) ? 8'h7F : 8'h80;
        ipsumV[0][0] = 32'h7FFF_FF00;
        applyStimulus(0, 0, 3, 0, 0, 0, 0, 0, 0, 1'b0, "t4_sat_chain");

        randomData();
        applyStimulus(0, 1, 3, 2, 1, 0, 0, 0, 0, 1'b0, "t5_nostall");
        applyStimulus(0, 1, 3, 2, 1, 0, 0, 3, 5, 1'b0, "t5_stall");

        randomData();
        applyStimulus(0, 3, 3, 2, 0, 0, 0, 0, 0, 1'b1, "t6_abort");
        applyStimulus(0, 3, 3, 2, 1, 1, 0, 1, 1, 1'b0, "t6_rerun");

        for (int n = 0; n < 8; n++) begin
            randomData();
            applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 1)), 2, int'($urandom_range(0, 3)), 1'b0,
                          $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
